// File: rtl/branch_predict_resolve.sv
// Execute-stage branch resolution with a bimodal 2-bit BHT and saturating branch/mispredict counters.
// Resolve outputs and BHT read are combinational; BHT/counter updates land on the next clk edge; never stalls.
module branch_predict_resolve #(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [XLEN-1:0]  pc_f,
  output logic             pred_taken_f,
  input  logic             valid_e,
  input  logic             kill_e,
  input  logic             branch_e,
  input  logic [2:0]       funct3_e,
  input  logic [XLEN-1:0]  rs1_e,
  input  logic [XLEN-1:0]  rs2_e,
  input  logic [XLEN-1:0]  pc_e,
  input  logic             pred_taken_e,
  output logic             pcsrc_e,
  output logic             mispredict_e,
  output logic             illegal_br_e,
  output logic [CNT_W-1:0] br_count,
  output logic [CNT_W-1:0] mis_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] idx_f;
  logic [IDX_W-1:0] idx_e;
  logic             cond;
  logic             rsv;
  logic             br_live;
  logic             act;

  assign idx_f = pc_f[IDX_W+1:2];
  assign idx_e = pc_e[IDX_W+1:2];

  // Word-offset bits and PC bits above the index never affect the table.
  logic unused_pc;
  assign unused_pc = ^{pc_f[XLEN-1:IDX_W+2], pc_f[1:0], pc_e[XLEN-1:IDX_W+2], pc_e[1:0]};

  always_comb begin
    cond = 1'b0;
    rsv  = 1'b0;
    case (funct3_e)
      3'b000:  cond = (rs1_e == rs2_e);
      3'b001:  cond = (rs1_e != rs2_e);
      3'b100:  cond = ($signed(rs1_e) <  $signed(rs2_e));
      3'b101:  cond = ($signed(rs1_e) >= $signed(rs2_e));
      3'b110:  cond = (rs1_e <  rs2_e);
      3'b111:  cond = (rs1_e >= rs2_e);
      default: rsv  = 1'b1;
    endcase
  end

  assign br_live      = valid_e & branch_e & ~kill_e;
  assign act          = br_live & ~rsv;
  assign illegal_br_e = br_live & rsv;
  assign pcsrc_e      = act & cond;
  assign mispredict_e = act & (cond ^ pred_taken_e);
  assign pred_taken_f = bht[idx_f][1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else if (act) begin
      if (cond && bht[idx_e] != 2'b11)
        bht[idx_e] <= bht[idx_e] + 2'b01;
      else if (!cond && bht[idx_e] != 2'b00)
        bht[idx_e] <= bht[idx_e] - 2'b01;
    end
  end

  // Statistics stick at all-ones rather than wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_count  <= '0;
      mis_count <= '0;
    end else begin
      if (act && br_count != '1)
        br_count <= br_count + 1'b1;
      if (mispredict_e && mis_count != '1)
        mis_count <= mis_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_branch_predict_resolve.sv
// Directed bench for branch_predict_resolve: reference model checked every cycle plus literal expectations.
module tb_branch_predict_resolve;

  localparam int ENT  = 64;
  localparam int CMAX = 15;

  logic        clk;
  logic        rst_n;
  logic [31:0] pc_f;
  logic        pred_taken_f;
  logic        valid_e, kill_e, branch_e, pred_taken_e;
  logic [2:0]  funct3_e;
  logic [31:0] rs1_e, rs2_e, pc_e;
  logic        pcsrc_e, mispredict_e, illegal_br_e;
  logic [3:0]  br_count, mis_count;

  int n_vec;
  int n_err;
  int bht_m [ENT];
  int br_m;
  int mis_m;

  branch_predict_resolve #(.XLEN(32), .BHT_ENTRIES(ENT), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .pc_f(pc_f), .pred_taken_f(pred_taken_f),
    .valid_e(valid_e), .kill_e(kill_e), .branch_e(branch_e), .funct3_e(funct3_e),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .pc_e(pc_e), .pred_taken_e(pred_taken_e),
    .pcsrc_e(pcsrc_e), .mispredict_e(mispredict_e), .illegal_br_e(illegal_br_e),
    .br_count(br_count), .mis_count(mis_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference rules, written from the branch semantics.
  function automatic bit m_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'd0:    return a == b;
      3'd1:    return a != b;
      3'd4:    return $signed(a) < $signed(b);
      3'd5:    return !($signed(a) < $signed(b));
      3'd6:    return a < b;
      3'd7:    return !(a < b);
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit m_rsv(input logic [2:0] f3);
    return (f3 == 3'd2) || (f3 == 3'd3);
  endfunction

  function automatic bit m_act();
    return valid_e && branch_e && !kill_e && !m_rsv(funct3_e);
  endfunction

  function automatic int m_idx(input logic [31:0] pc);
    return int'((pc >> 2) % ENT);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ENT; i++) bht_m[i] <= 1;
      br_m  <= 0;
      mis_m <= 0;
    end else if (m_act()) begin
      if (m_taken(funct3_e, rs1_e, rs2_e))
        bht_m[m_idx(pc_e)] <= (bht_m[m_idx(pc_e)] < 3) ? bht_m[m_idx(pc_e)] + 1 : 3;
      else
        bht_m[m_idx(pc_e)] <= (bht_m[m_idx(pc_e)] > 0) ? bht_m[m_idx(pc_e)] - 1 : 0;
      br_m <= (br_m < CMAX) ? br_m + 1 : CMAX;
      if (m_taken(funct3_e, rs1_e, rs2_e) != pred_taken_e)
        mis_m <= (mis_m < CMAX) ? mis_m + 1 : CMAX;
    end
  end

  always @(negedge clk) begin
    chk("m_pred_f",  32'(pred_taken_f), 32'(bht_m[m_idx(pc_f)] >= 2));
    chk("m_pcsrc",   32'(pcsrc_e),      32'(m_act() && m_taken(funct3_e, rs1_e, rs2_e)));
    chk("m_misp",    32'(mispredict_e), 32'(m_act() && (m_taken(funct3_e, rs1_e, rs2_e) != pred_taken_e)));
    chk("m_illegal", 32'(illegal_br_e), 32'(valid_e && branch_e && !kill_e && m_rsv(funct3_e)));
    chk("m_br_cnt",  32'(br_count),     32'(br_m));
    chk("m_mis_cnt", 32'(mis_count),    32'(mis_m));
  end

  task automatic drive(input logic v, input logic k, input logic b, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] bb, input logic [31:0] pc,
                       input logic pr);
    valid_e = v; kill_e = k; branch_e = b; funct3_e = f3;
    rs1_e = a; rs2_e = bb; pc_e = pc; pred_taken_e = pr;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 3'd0, 32'd0, 32'd0, 32'd0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [2:0] f3_tab  [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
  logic       pc_tab  [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
  logic       tk_tab  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic       pr_tab  [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic       ms_tab  [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic       pf_tab  [6] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  int         ctr_tab [6] = '{2, 3, 3, 3, 2, 1};

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n = 1'b0;
    pc_f  = 32'd0;
    idle();
    #12 rst_n = 1'b1;
    tick();

    for (int i = 0; i < ENT; i++) begin
      pc_f = 32'(i * 4);
      @(negedge clk);
      chk("reset_pred", 32'(pred_taken_f), 32'd0);
      tick();
    end
    chk("reset_br", 32'(br_count), 32'd0);
    chk("reset_mis", 32'(mis_count), 32'd0);

    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, 1'b1, f3_tab[i], 32'hFFFF_FFFF, 32'h0000_0001, 32'h10, 1'b0);
      @(negedge clk);
      chk("sweep_pcsrc", 32'(pcsrc_e), 32'(pc_tab[i]));
      chk("sweep_misp", 32'(mispredict_e), 32'(pc_tab[i]));
      tick();
    end
    idle();

    pc_f = 32'h100;
    for (int j = 0; j < 6; j++) begin
      drive(1'b1, 1'b0, 1'b1, 3'd0, 32'd5, tk_tab[j] ? 32'd5 : 32'd6, 32'h100, pr_tab[j]);
      @(negedge clk);
      chk("sat_pcsrc", 32'(pcsrc_e), 32'(tk_tab[j]));
      chk("sat_misp", 32'(mispredict_e), 32'(ms_tab[j]));
      if (j == 0) chk("same_cycle_pred", 32'(pred_taken_f), 32'd0);
      tick();
      idle();
      @(negedge clk);
      chk("sat_pred", 32'(pred_taken_f), 32'(pf_tab[j]));
      chk("model_ctr", 32'(bht_m[0]), 32'(ctr_tab[j]));
      if (j == 4) begin
        pc_f = 32'h200;
        #1 chk("alias_200", 32'(pred_taken_f), 32'd1);
        pc_f = 32'h104;
        #1 chk("alias_104", 32'(pred_taken_f), 32'd0);
        pc_f = 32'h100;
      end
      tick();
    end
    chk("after_sat_br", 32'(br_count), 32'd12);
    chk("after_sat_mis", 32'(mis_count), 32'd5);

    pc_f = 32'h104;
    drive(1'b1, 1'b1, 1'b1, 3'd0, 32'd7, 32'd7, 32'h104, 1'b0);
    @(negedge clk);
    chk("kill_pcsrc", 32'(pcsrc_e), 32'd0);
    chk("kill_misp", 32'(mispredict_e), 32'd0);
    tick();

    drive(1'b1, 1'b0, 1'b1, 3'b010, 32'd7, 32'd7, 32'h104, 1'b1);
    @(negedge clk);
    chk("ill010_flag", 32'(illegal_br_e), 32'd1);
    chk("ill010_pcsrc", 32'(pcsrc_e), 32'd0);
    chk("ill010_misp", 32'(mispredict_e), 32'd0);
    tick();
    drive(1'b1, 1'b0, 1'b1, 3'b011, 32'd7, 32'd7, 32'h104, 1'b0);
    @(negedge clk);
    chk("ill011_flag", 32'(illegal_br_e), 32'd1);
    tick();
    drive(1'b1, 1'b1, 1'b1, 3'b010, 32'd7, 32'd7, 32'h104, 1'b0);
    @(negedge clk);
    chk("ill_killed", 32'(illegal_br_e), 32'd0);
    tick();
    idle();
    @(negedge clk);
    chk("kill_ill_pred", 32'(pred_taken_f), 32'd0);
    chk("kill_ill_br", 32'(br_count), 32'd12);
    chk("kill_ill_mis", 32'(mis_count), 32'd5);
    tick();

    pc_f = 32'h100;
    for (int j = 0; j < 2; j++) begin
      drive(1'b1, 1'b0, 1'b1, 3'd0, 32'd3, 32'd3, 32'h100, 1'b1);
      tick();
    end
    for (int j = 0; j < 20; j++) begin
      drive(1'b1, 1'b0, 1'b1, 3'd1, 32'd9, 32'd9, 32'h20, 1'b1);
      tick();
    end
    idle();
    @(negedge clk);
    chk("cnt_sat_br", 32'(br_count), 32'd15);
    chk("cnt_sat_mis", 32'(mis_count), 32'd15);
    chk("pre_rst_pred", 32'(pred_taken_f), 32'd1);
    tick();

    drive(1'b1, 1'b0, 1'b1, 3'd0, 32'd5, 32'd5, 32'h100, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_br", 32'(br_count), 32'd0);
    chk("arst_mis", 32'(mis_count), 32'd0);
    chk("arst_pred", 32'(pred_taken_f), 32'd0);
    chk("arst_pcsrc", 32'(pcsrc_e), 32'd1);
    tick();
    chk("in_rst_br", 32'(br_count), 32'd0);
    chk("in_rst_pred", 32'(pred_taken_f), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    idle();
    @(negedge clk);
    chk("post_rst_br", 32'(br_count), 32'd1);
    chk("post_rst_mis", 32'(mis_count), 32'd1);
    chk("post_rst_pred", 32'(pred_taken_f), 32'd1);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/branch_predict_resolve.md
# branch_predict_resolve

Execute-stage branch unit for the pipelined RV32I core. It resolves all six RISC-V conditional branches directly from the operand values, so no external ALU flags are needed. It also keeps a parametrised bimodal branch history table (BHT) of 2-bit saturating counters that the fetch stage reads, and it reports mispredictions for pipeline flush. Two saturating statistics counters track resolved branches and mispredictions.

## Interface
- XLEN, 32, operand and PC width
- BHT_ENTRIES, 64, number of BHT entries; power of two, ≥2
- CNT_W, 16, width of the statistics counters
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- pc_f  input  XLEN  fetch-stage PC used for the BHT lookup
- pred_taken_f  output  1  prediction for pc_f; equals MSB of the indexed counter
- valid_e  input  1  execute-stage instruction is valid
- kill_e  input  1  execute-stage instruction is being squashed this cycle
- branch_e  input  1  execute-stage instruction is a conditional branch
- funct3_e  input  3  branch condition
- rs1_e, rs2_e  input  XLEN  branch operands
- pc_e  input  XLEN  PC of the execute-stage branch
- pred_taken_e  input  1  prediction carried down the pipe from fetch
- pcsrc_e  output  1  branch taken (selects branch target)
- mispredict_e  output  1  resolved direction differs from pred_taken_e
- illegal_br_e  output  1  branch_e with reserved funct3 (010/011)
- br_count  output  CNT_W  resolved-branch count
- mis_count  output  CNT_W  misprediction count

## Operation
- Index = pc[log2(BHT_ENTRIES)+1 : 2], the same slice for pc_f and pc_e.
- Active resolve: act = valid_e & branch_e & ~kill_e & ~illegal_br_e.
- Condition by funct3:
  - 000: rs1==rs2
  - 001: rs1!=rs2
  - 100: signed rs1<rs2
  - 101: signed rs1>=rs2
  - 110: unsigned rs1<rs2
  - 111: unsigned rs1>=rs2
  - 010/011: cond=0.
- pcsrc_e = act & cond.
- mispredict_e = act & (cond ^ pred_taken_e).
- illegal_br_e = valid_e & branch_e & ~kill_e & (funct3_e ∈ {010,011}).
- BHT update on the clock edge when act is high:
  - Taken: counter increments, saturating at 2'b11.
  - Not taken: counter decrements, saturating at 2'b00.
- When act is low, the BHT and the statistics counters hold their values.
- br_count increments by 1 when act is high; mis_count increments by 1 when mispredict_e is high. Both saturate at 2^CNT_W−1 and do not wrap.
- Counter encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.

## Timing
- pcsrc_e, mispredict_e, illegal_br_e and pred_taken_f are combinational in the same cycle; there are no registers on the resolve path.
- A BHT update becomes visible on pred_taken_f from the cycle after the update edge.
- Same-index read and update in one cycle: pred_taken_f shows the pre-update value.
- Reset (asynchronous, rst_n low):
  - Every BHT entry is set to 2'b01, so pred_taken_f=0.
  - br_count=0, mis_count=0.
  - Combinational outputs follow their inputs and are gated by act.
- Reset asserted mid-stream: any update in flight is discarded. After rst_n rises, the first update happens on the first edge with act high.
- kill_e high in the same cycle as a branch: no update, no counting, pcsrc_e=0, mispredict_e=0.

## Test plan
- Reset, then sweep pc_f over all indices → pred_taken_f=0 everywhere; br_count=mis_count=0.
- Condition sweep, all six conditions with rs1=0xFFFFFFFF and rs2=0x00000001, pred_taken_e=0 → pcsrc_e is 0,1,1,0,0,1 for funct3 000,001,100,101,110,111; mispredict_e equals pcsrc_e each time.
- Saturation: four taken BEQs at pc_e=0x100, then one not-taken:
  - Counter goes 01→10→11→11→11→10.
  - pred_taken_f at pc_f=0x100 reads 1 from the cycle after the first update.
- Aliasing with BHT_ENTRIES=64: update at pc_e=0x100 is also visible at pc_f=0x200; pc_f=0x104 is unaffected.
- Kill and illegal cases:
  - kill_e=1 with a taken branch → no BHT change, no counts.
  - funct3=010 → illegal_br_e=1, pcsrc_e=0, no update.
- Counter saturation and reset: with CNT_W=4, 20 mispredicting branches → br_count=mis_count=15. Assert rst_n low mid-run → counters and BHT return to reset values immediately, without waiting for a clock edge.
